alu_seq: RTL
============

Name: alu_seq

Overview:
- Parametrised, registered ALU for the BasicCPU datapath. It is the successor to the 8-bit add/sub unit.
- Adds the following over the add/sub unit:
  - configurable width
  - logic, shift, compare and carry-chained ops
  - a full NZCV flag register
  - an iterative shift-add multiplier with a start/busy/valid handshake
- Sits between the A/B registers and the CPU result bus. The sequencer issues one op per i_start and samples the result when o_valid is high.

Parameters:
- WIDTH, 8: operand/result width in bits, legal range 4..32.
- CNT_W, $clog2(WIDTH+1): width of the multiplier iteration counter (derived, do not override).

Ports:
- i_clk  in  1  clock; all state changes on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle request; captures i_op, i_data_a, i_data_b.
- i_op  in  4  operation code (alu_pkg).
- i_data_a  in  WIDTH  operand A.
- i_data_b  in  WIDTH  operand B.
- i_flags_clr  in  1  clears NZCV to 0 (sync); lower priority than reset, higher than an op completion.
- o_result  out  WIDTH  registered result (MUL: low half).
- o_result_hi  out  WIDTH  MUL high half; 0 for all other ops.
- o_valid  out  1  one-cycle pulse: o_result/o_result_hi/flags updated this cycle.
- o_busy  out  1  high while a multi-cycle op is in progress.
- o_flag_n, o_flag_z, o_flag_c, o_flag_v  out  1 each  registered flags.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, multiplier counter 0. Reset mid-multiply aborts the op; no o_valid is produced.
- FSM states:
  - IDLE: accepts i_start.
  - MUL: iterating.
  - Transitions: IDLE to MUL on i_start with op MUL; MUL to IDLE after WIDTH iterations.
- Single-cycle ops (all except MUL):
  - i_start at edge k gives result, flags and an o_valid pulse at edge k+1.
  - Back-to-back i_start every cycle is legal.
  - o_busy stays 0.
- MUL:
  - Operands are captured at the start edge; o_busy is 1 from the next cycle.
  - One shift-add step per cycle, WIDTH steps, unsigned product of width 2*WIDTH.
  - On completion, o_valid pulses and o_busy drops. o_valid therefore occurs WIDTH+1 edges after start.
- i_start while o_busy=1 is ignored: no capture, no effect on the running op.
- Op semantics:
  - ADD/ADC: a+b(+C).
  - SUB/SBC: a-b(-C). C means borrow, set when the unsigned true result < 0.
  - AND/OR/XOR: C=0, V=0.
  - NOT (of a): C=0, V=0.
  - SHL/SHR: logical 1-bit shift of a. C = bit shifted out; V=0.
  - CMP: as SUB but writes flags only; o_result is held and o_valid still pulses.
  - PASSB: result = b, C=0, V=0.
  - MUL: C = (high half != 0), V=0.
- Flags:
  - Z = (result == 0). For MUL, Z covers the full 2*WIDTH product.
  - N = result MSB. For MUL, N = MSB of the high half.
  - V = signed overflow for ADD/ADC/SUB/SBC/CMP, computed from operand and result MSBs.
  - Flags change only on o_valid or i_flags_clr.
  - ADC/SBC use the C value registered before the current op.
- Undefined op codes: treated as PASSB.
- Width rule: arithmetic is done in WIDTH+1 bits; bit WIDTH gives carry/borrow.

Decomposition:
- alu_pkg holds:
  - 4-bit op-code constants: ADD=0, SUB=1, ADC=2, SBC=3, AND=4, OR=5, XOR=6, NOT=7, SHL=8, SHR=9, CMP=10, PASSB=11, MUL=12.
  - FSM state encoding: IDLE, MUL.
- Sub-module alu_mul_iter holds the shift-add multiplier: start/busy/done, WIDTH parameter, sync reset.
- alu_seq holds the combinational op decode, the registers and the flags.

Test Plan (WIDTH=8):
- ADD 0xFF+0x01 -> o_result=0x00, Z=1, C=1, N=0, V=0; o_valid exactly one cycle after i_start.
- ADD 0x7F+0x01 -> 0x80, N=1, V=1, C=0. Then SUB 0x10-0x20 -> 0xF0, C=1 (borrow), N=1, V=0.
- ADC carry chain:
  - ADD 0xFF+0x01 gives C=1.
  - Then ADC 0x00+0x00 -> 0x01, C=0.
  - Then CMP 0x05,0x05 -> Z=1, C=0, o_result still 0x01.
- MUL 0x0F*0x11:
  - o_busy high for 8 cycles; o_valid 9 edges after start.
  - Result hi=0x00, lo=0xFF, C=0.
- MUL 0xFF*0xFF:
  - Result hi=0xFE, lo=0x01, C=1, N=1.
  - An i_start with ADD during busy is ignored; the result is unchanged.
- Reset and flag clear:
  - Assert i_reset at multiply step 4: next cycle all outputs 0, o_busy=0, no o_valid.
  - SHL 0x81 -> 0x02, C=1.
  - i_flags_clr -> NZCV=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared op codes, FSM encoding and flag bundle for the sequenced ALU.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_ADC   = 4'd2;
    localparam logic [3:0] OP_SBC   = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_OR    = 4'd5;
    localparam logic [3:0] OP_XOR   = 4'd6;
    localparam logic [3:0] OP_NOT   = 4'd7;
    localparam logic [3:0] OP_SHL   = 4'd8;
    localparam logic [3:0] OP_SHR   = 4'd9;
    localparam logic [3:0] OP_CMP   = 4'd10;
    localparam logic [3:0] OP_PASSB = 4'd11;
    localparam logic [3:0] OP_MUL   = 4'd12;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial-product step per cycle.
// Latency: WIDTH steps after the start edge, then a one-cycle o_done pulse.
// Backpressure: o_busy high while stepping; i_start only honoured in IDLE.
module alu_mul_iter #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_mcand,
    input  logic [WIDTH-1:0] i_mplier,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_prod_hi,
    output logic [WIDTH-1:0] o_prod_lo
);
    import alu_pkg::*;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;
    logic [WIDTH:0]   step_sum;
    logic             last_step;

    // The multiplier sits in lo_q and is consumed LSB first; the product
    // shifts in from the top so {hi_q, lo_q} holds it after WIDTH steps.
    assign step_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next state: leave IDLE on start, return after the final step.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (i_start)   state_d = ST_MUL;
            ST_MUL:  if (last_step) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand capture, shift-add datapath, step counter and done pulse.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q   <= '0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == ST_IDLE && i_start) begin
                mcand_q <= i_mcand;
                lo_q    <= i_mplier;
                hi_q    <= '0;
                cnt_q   <= '0;
            end else if (state_q == ST_MUL) begin
                hi_q <= step_sum[WIDTH:1];
                lo_q <= {step_sum[0], lo_q[WIDTH-1:1]};
                if (last_step) begin
                    cnt_q  <= '0;
                    done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign o_busy    = (state_q == ST_MUL);
    assign o_done    = done_q;
    assign o_prod_hi = hi_q;
    assign o_prod_lo = lo_q;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with NZCV flags and an iterative multiplier for the CPU datapath.
// Latency: 1 edge for single-cycle ops, WIDTH+1 edges for MUL.
// Backpressure: i_start ignored while a MUL is busy or its result is pending.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [3:0]       i_op,
    input  logic [WIDTH-1:0] i_data_a,
    input  logic [WIDTH-1:0] i_data_b,
    input  logic             i_flags_clr,
    output logic [WIDTH-1:0] o_result,
    output logic [WIDTH-1:0] o_result_hi,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_flag_n,
    output logic             o_flag_z,
    output logic             o_flag_c,
    output logic             o_flag_v
);
    import alu_pkg::*;

    flags_t           flags_q;
    flags_t           alu_flags;
    flags_t           mul_flags;
    logic [WIDTH:0]   res_x;
    logic [WIDTH-1:0] alu_res;
    logic             write_res;
    logic             is_add;
    logic             is_sub;
    logic             accept;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_hi;
    logic [WIDTH-1:0] mul_lo;

    // The cycle between the last multiply step and the result register
    // update is also closed to new requests, so a single-cycle op can never
    // collide with a MUL completion.
    assign accept    = i_start && !mul_busy && !mul_done;
    assign mul_start = accept && (i_op == OP_MUL);

    alu_mul_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_mul (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_start   (mul_start),
        .i_mcand   (i_data_a),
        .i_mplier  (i_data_b),
        .o_busy    (mul_busy),
        .o_done    (mul_done),
        .o_prod_hi (mul_hi),
        .o_prod_lo (mul_lo)
    );

    // Single-cycle op decode in WIDTH+1 bits; bit WIDTH is carry/borrow.
    always_comb begin
        res_x     = '0;
        write_res = 1'b1;
        is_add    = 1'b0;
        is_sub    = 1'b0;
        alu_flags = '0;
        case (i_op)
            OP_ADD: begin
                res_x  = {1'b0, i_data_a} + {1'b0, i_data_b};
                is_add = 1'b1;
            end
            OP_ADC: begin
                res_x  = {1'b0, i_data_a} + {1'b0, i_data_b} + {{WIDTH{1'b0}}, flags_q.c};
                is_add = 1'b1;
            end
            OP_SUB: begin
                res_x  = {1'b0, i_data_a} - {1'b0, i_data_b};
                is_sub = 1'b1;
            end
            OP_SBC: begin
                res_x  = {1'b0, i_data_a} - {1'b0, i_data_b} - {{WIDTH{1'b0}}, flags_q.c};
                is_sub = 1'b1;
            end
            OP_CMP: begin
                res_x     = {1'b0, i_data_a} - {1'b0, i_data_b};
                is_sub    = 1'b1;
                write_res = 1'b0;
            end
            OP_AND: res_x = {1'b0, i_data_a & i_data_b};
            OP_OR:  res_x = {1'b0, i_data_a | i_data_b};
            OP_XOR: res_x = {1'b0, i_data_a ^ i_data_b};
            OP_NOT: res_x = {1'b0, ~i_data_a};
            OP_SHL: begin
                res_x       = {1'b0, i_data_a[WIDTH-2:0], 1'b0};
                alu_flags.c = i_data_a[WIDTH-1];
            end
            OP_SHR: begin
                res_x       = {2'b00, i_data_a[WIDTH-1:1]};
                alu_flags.c = i_data_a[0];
            end
            default: res_x = {1'b0, i_data_b};
        endcase
        alu_res     = res_x[WIDTH-1:0];
        alu_flags.n = alu_res[WIDTH-1];
        alu_flags.z = (alu_res == '0);
        if (is_add) begin
            alu_flags.c = res_x[WIDTH];
            alu_flags.v = (i_data_a[WIDTH-1] == i_data_b[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != i_data_a[WIDTH-1]);
        end
        if (is_sub) begin
            alu_flags.c = res_x[WIDTH];
            alu_flags.v = (i_data_a[WIDTH-1] != i_data_b[WIDTH-1]) &&
                          (alu_res[WIDTH-1] != i_data_a[WIDTH-1]);
        end
    end

    // MUL flags: Z over the full product, N from the top of the high half.
    always_comb begin
        mul_flags   = '0;
        mul_flags.n = mul_hi[WIDTH-1];
        mul_flags.z = ({mul_hi, mul_lo} == '0);
        mul_flags.c = (mul_hi != '0);
    end

    // Result, flag and valid registers; flag clear beats any completion.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_result    <= '0;
            o_result_hi <= '0;
            o_valid     <= 1'b0;
            flags_q     <= '0;
        end else begin
            o_valid <= 1'b0;
            if (mul_done) begin
                o_result    <= mul_lo;
                o_result_hi <= mul_hi;
                flags_q     <= mul_flags;
                o_valid     <= 1'b1;
            end else if (accept && i_op != OP_MUL) begin
                if (write_res) o_result <= alu_res;
                o_result_hi <= '0;
                flags_q     <= alu_flags;
                o_valid     <= 1'b1;
            end
            if (i_flags_clr) flags_q <= '0;
        end
    end

    assign o_busy   = mul_busy;
    assign o_flag_n = flags_q.n;
    assign o_flag_z = flags_q.z;
    assign o_flag_c = flags_q.c;
    assign o_flag_v = flags_q.v;

endmodule
